// File: rtl/heap_array_allocator_pkg.sv
// heap_array_allocator_pkg: opcodes, error codes, FSM states and default sizing for the heap allocator
// Default sizing: 12-bit words, 10 words per array, 200 arrays; widths derived below.
package heap_array_allocator_pkg;
  localparam int W_DEF = 12;
  localparam int NAREA_DEF = 10;
  localparam int NARRAYS_DEF = 200;
  localparam int AW_DEF = $clog2(NARRAYS_DEF);
  localparam int IW_DEF = $clog2(NAREA_DEF);
  localparam int CW_DEF = $clog2(NARRAYS_DEF + 1);
  typedef enum logic [2:0] {OP_ALLOC, OP_FREE, OP_READ, OP_WRITE, OP_SIZE, OP_ADD} op_t;
  typedef enum logic [1:0] {E_OK, E_BOUNDS, E_UNALLOC, E_FULL} err_t;
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_RD, S_RMW1, S_RMW2, S_RESP} state_t;
endpackage

// File: rtl/heap_array_allocator_if.sv
// heap_array_allocator_if: request/response handshake bundle between sequencer and allocator
// req_*: valid/ready command (op, array, index, data); rsp_*: valid/ready result (data, error).
interface heap_array_allocator_if
  import heap_array_allocator_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
);
  logic req_valid;
  logic req_ready;
  logic [2:0] req_op;
  logic [AW-1:0] req_array;
  logic [IW:0] req_index;
  logic [W-1:0] req_data;
  logic rsp_valid;
  logic rsp_ready;
  logic [W-1:0] rsp_data;
  logic [1:0] rsp_error;
  modport master (
    output req_valid, req_op, req_array, req_index, req_data, rsp_ready,
    input req_ready, rsp_valid, rsp_data, rsp_error
  );
  modport slave (
    input req_valid, req_op, req_array, req_index, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_error
  );
endinterface

// File: rtl/heap_array_allocator_free_stack.sv
// heap_array_allocator_free_stack: LIFO of freed array numbers
// Ports: clock/reset, i_push with i_data, i_pop, o_empty, o_top (most recent push).
module heap_array_allocator_free_stack #(
  parameter int DEPTH = 200,
  parameter int WIDTH = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic i_push,
  input  logic i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic o_empty,
  output logic [WIDTH-1:0] o_top
);
  localparam int PW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_sp;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_sp <= '0;
    else if (i_push) r_sp <= r_sp + PW'(1);
    else if (i_pop) r_sp <= r_sp - PW'(1);
  always_ff @(posedge clock)
    if (i_push) r_mem[r_sp] <= i_data;
  assign o_empty = r_sp == '0;
  assign o_top = r_mem[r_sp - PW'(1)];
endmodule

// File: rtl/heap_array_allocator.sv
// heap_array_allocator: command-driven heap owner with bounds, double-free and exhaustion checks
// Ports: clock, reset (async, active-high), bus (slave handshake), allocs (ever issued), in_use (live arrays).
module heap_array_allocator
  import heap_array_allocator_pkg::*;
#(
  parameter int MemoryElementWidth = W_DEF,
  parameter int NArea = NAREA_DEF,
  parameter int NArrays = NARRAYS_DEF,
  localparam int W = MemoryElementWidth,
  localparam int AW = $clog2(NArrays),
  localparam int IW = $clog2(NArea),
  localparam int CW = $clog2(NArrays + 1),
  localparam int HW = $clog2(NArrays * NArea),
  localparam int SW = $clog2(NArea + 1)
) (
  input  logic clock,
  input  logic reset,
  heap_array_allocator_if.slave bus,
  output logic [CW-1:0] allocs,
  output logic [CW-1:0] in_use
);
  state_t r_state, w_next;
  logic [2:0] r_op;
  logic [AW-1:0] r_array;
  logic [IW:0] r_index;
  logic [W-1:0] r_data, r_rd, r_sum, r_rsp_data;
  err_t r_rsp_err, w_err;
  logic [CW-1:0] r_allocs, r_in_use;
  // Sized to the full array-number space so numbers >= NArrays read as never allocated.
  logic [2**AW-1:0] r_bitmap;
  logic [W-1:0] r_heap [NArrays*NArea];
  logic [SW-1:0] r_size [NArrays];
  logic w_exec, w_ok, w_idx_op, w_empty, w_push, w_pop, w_heap_we;
  logic [AW-1:0] w_top, w_alloc_a;
  logic [HW-1:0] w_addr;
  logic [SW-1:0] w_len;
  logic [W-1:0] w_exec_data;
  assign w_exec = r_state == S_EXEC;
  assign w_idx_op = r_op == OP_READ || r_op == OP_WRITE || r_op == OP_ADD;
  assign w_err = r_op > OP_ADD ? E_FULL
    : (r_op != OP_ALLOC && !r_bitmap[r_array]) ? E_UNALLOC
    : (w_idx_op && r_index >= (IW+1)'(NArea)) ? E_BOUNDS
    : (r_op == OP_ALLOC && w_empty && r_allocs >= CW'(NArrays)) ? E_FULL : E_OK;
  assign w_ok = w_err == E_OK;
  assign w_alloc_a = w_empty ? AW'(r_allocs) : w_top;
  assign w_addr = HW'(r_array) * HW'(NArea) + HW'(r_index);
  assign w_len = SW'(r_index) + SW'(1);
  assign w_push = w_exec && w_ok && r_op == OP_FREE;
  assign w_pop = w_exec && w_ok && r_op == OP_ALLOC && !w_empty;
  assign w_heap_we = (w_exec && w_ok && r_op == OP_WRITE) || r_state == S_RMW2;
  assign w_exec_data = r_op == OP_ALLOC ? W'(w_alloc_a)
    : r_op == OP_WRITE ? r_data
    : r_op == OP_SIZE ? W'(r_size[r_array]) : '0;
  heap_array_allocator_free_stack #(.DEPTH(NArrays), .WIDTH(AW)) u_stack (
    .clock(clock),
    .reset(reset),
    .i_push(w_push),
    .i_pop(w_pop),
    .i_data(r_array),
    .o_empty(w_empty),
    .o_top(w_top)
  );
  always_ff @(posedge clock) begin
    if (w_heap_we) r_heap[w_addr] <= r_state == S_RMW2 ? r_sum : r_data;
    r_rd <= r_heap[w_addr];
  end
  always_ff @(posedge clock)
    if (w_exec && w_ok && r_op == OP_ALLOC) r_size[w_alloc_a] <= '0;
    else if (w_exec && w_ok && r_op == OP_WRITE && r_size[r_array] < w_len) r_size[r_array] <= w_len;
  always_ff @(posedge clock or posedge reset)
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = bus.req_valid ? S_EXEC : S_IDLE;
      S_EXEC: w_next = !w_ok ? S_RESP : r_op == OP_READ ? S_RD : r_op == OP_ADD ? S_RMW1 : S_RESP;
      S_RD, S_RMW2: w_next = S_RESP;
      S_RMW1: w_next = S_RMW2;
      S_RESP: w_next = bus.rsp_ready ? S_IDLE : S_RESP;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_op <= '0;
      r_array <= '0;
      r_index <= '0;
      r_data <= '0;
      r_sum <= '0;
      r_rsp_data <= '0;
      r_rsp_err <= E_OK;
      r_allocs <= '0;
      r_in_use <= '0;
      r_bitmap <= '0;
    end else begin
      if (r_state == S_IDLE && bus.req_valid) begin
        r_op <= bus.req_op;
        r_array <= bus.req_array;
        r_index <= bus.req_index;
        r_data <= bus.req_data;
      end
      if (w_exec) begin
        r_rsp_err <= w_err;
        r_rsp_data <= w_ok ? w_exec_data : '0;
      end
      if (w_exec && w_ok && r_op == OP_ALLOC) begin
        r_bitmap[w_alloc_a] <= 1'b1;
        r_in_use <= r_in_use + CW'(1);
        if (w_empty) r_allocs <= r_allocs + CW'(1);
      end
      if (w_push) begin
        r_bitmap[r_array] <= 1'b0;
        r_in_use <= r_in_use - CW'(1);
      end
      if (r_state == S_RD) r_rsp_data <= r_rd;
      if (r_state == S_RMW1) r_sum <= r_rd + r_data;
      if (r_state == S_RMW2) r_rsp_data <= r_sum;
    end
  end
  assign bus.req_ready = r_state == S_IDLE;
  assign bus.rsp_valid = r_state == S_RESP;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_error = r_rsp_err;
  assign allocs = r_allocs;
  assign in_use = r_in_use;
endmodule

// File: tb/tb_heap_array_allocator.sv
// tb_heap_array_allocator: directed plan plus random commands checked against a behavioural heap model
module tb_heap_array_allocator;
  localparam int NA = 200;
  localparam int NAREA = 10;
  logic clock = 0;
  logic reset = 1;
  logic [7:0] allocs, in_use;
  heap_array_allocator_if #(.W(12), .AW(8), .IW(4)) bus();
  heap_array_allocator dut (
    .clock(clock),
    .reset(reset),
    .bus(bus),
    .allocs(allocs),
    .in_use(in_use)
  );
  always #5 clock = ~clock;
  int checks = 0;
  int failures = 0;
  int k = 0;
  int exp_data = 0, exp_err = 0, exp_lat = 2;
  int m_allocs = 0, m_inuse = 0;
  bit m_bm [NA];
  int m_size [NA];
  int m_heap [int];
  int m_stk [$];
  int last_data = 0, last_err = 0, last_lat = 0;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference: plain arrays and a queue, updated once per accepted command.
  task automatic model(input int op, input int a, input int i, input int d);
    int addr, na;
    addr = a * NAREA + i;
    exp_lat = 2;
    exp_data = 0;
    if (op > 5) exp_err = 3;
    else if (op != 0 && (a >= NA || !m_bm[a])) exp_err = 2;
    else if ((op == 2 || op == 3 || op == 5) && i >= NAREA) exp_err = 1;
    else if (op == 0 && m_stk.size() == 0 && m_allocs >= NA) exp_err = 3;
    else begin
      exp_err = 0;
      case (op)
        0: begin
          if (m_stk.size() > 0) na = m_stk.pop_back();
          else begin
            na = m_allocs;
            m_allocs++;
          end
          m_size[na] = 0;
          m_bm[na] = 1;
          m_inuse++;
          exp_data = na;
        end
        1: begin
          m_stk.push_back(a);
          m_bm[a] = 0;
          m_inuse--;
        end
        2: begin
          exp_lat = 3;
          exp_data = m_heap.exists(addr) ? m_heap[addr] : -1;
        end
        3: begin
          m_heap[addr] = d;
          if (m_size[a] < i + 1) m_size[a] = i + 1;
          exp_data = d;
        end
        4: exp_data = m_size[a];
        default: begin
          exp_lat = 4;
          if (m_heap.exists(addr)) begin
            m_heap[addr] = (m_heap[addr] + d) % 4096;
            exp_data = m_heap[addr];
          end else exp_data = -1;
        end
      endcase
    end
  endtask

  // k = edges since the accepting edge of the outstanding command, 0 when idle.
  initial forever begin
    @(posedge clock);
    if (reset) k = 0;
    else if (bus.req_valid && bus.req_ready) k = 1;
    else if (k != 0 && bus.rsp_valid && bus.rsp_ready) k = 0;
    else if (k != 0) k++;
  end

  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (k == 0) begin
        chk("idle_req_ready", bus.req_ready, 1);
        chk("idle_rsp_valid", bus.rsp_valid, 0);
        chk("idle_allocs", allocs, m_allocs);
        chk("idle_in_use", in_use, m_inuse);
      end else begin
        chk("busy_req_ready", bus.req_ready, 0);
        chk("rsp_timing", bus.rsp_valid, k >= exp_lat);
        if (bus.rsp_valid) begin
          chk("rsp_error", bus.rsp_error, exp_err);
          if (exp_data >= 0) chk("rsp_data", bus.rsp_data, exp_data);
          chk("rsp_allocs", allocs, m_allocs);
          chk("rsp_in_use", in_use, m_inuse);
        end
      end
    end
  end

  task automatic cmd(input int op, input int a, input int i, input int d,
                     input int hold = 0, input bit abort = 0);
    int n;
    n = 0;
    @(negedge clock);
    while (!bus.req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    bus.req_valid = 1;
    bus.req_op = 3'(op);
    bus.req_array = 8'(a);
    bus.req_index = 5'(i);
    bus.req_data = 12'(d);
    bus.rsp_ready = hold == 0;
    @(posedge clock);
    #1;
    bus.req_valid = 0;
    if (abort) begin
      exp_lat = 4;
      exp_data = -1;
      exp_err = 0;
      @(posedge clock);
      #1;
      reset = 1;
      #2;
      chk("abort_rsp_valid", bus.rsp_valid, 0);
      chk("abort_req_ready", bus.req_ready, 1);
      chk("abort_in_use", in_use, 0);
      chk("abort_allocs", allocs, 0);
      m_allocs = 0;
      m_inuse = 0;
      m_stk.delete();
      foreach (m_bm[j]) m_bm[j] = 0;
      @(posedge clock);
      #1;
      reset = 0;
      bus.rsp_ready = 1;
      return;
    end
    model(op, a, i, d);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!bus.rsp_valid) begin
      chk("rsp_timeout", 0, 1);
      bus.rsp_ready = 1;
      return;
    end
    last_lat = k;
    repeat (hold) @(negedge clock);
    bus.rsp_ready = 1;
    last_data = bus.rsp_data;
    last_err = bus.rsp_error;
    @(posedge clock);
    #1;
  endtask

  initial begin
    int r, op, a;
    bus.req_valid = 0;
    bus.req_op = 0;
    bus.req_array = 0;
    bus.req_index = 0;
    bus.req_data = 0;
    bus.rsp_ready = 1;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    chk("reset_rsp_data", bus.rsp_data, 0);
    chk("reset_rsp_error", bus.rsp_error, 0);
    chk("reset_req_ready", bus.req_ready, 1);
    // allocation and LIFO reuse
    cmd(0, 0, 0, 0); chk("t1_alloc_first", last_data, 0);
    cmd(0, 0, 0, 0); chk("t1_alloc_second", last_data, 1);
    chk("t1_allocs", allocs, 2);
    chk("t1_in_use", in_use, 2);
    cmd(1, 0, 0, 0); chk("t1_free_ok", last_err, 0);
    chk("t1_in_use_after_free", in_use, 1);
    cmd(0, 0, 0, 0); chk("t1_reuse", last_data, 0);
    chk("t1_allocs_kept", allocs, 2);
    // write/read/size
    cmd(3, 0, 2, 7);
    cmd(4, 0, 0, 0); chk("t2_size3", last_data, 3);
    cmd(2, 0, 2, 0); chk("t2_read", last_data, 7);
    chk("t2_read_latency", last_lat, 3);
    cmd(3, 0, 0, 5);
    cmd(4, 0, 0, 0); chk("t2_size_kept", last_data, 3);
    // add and wrap
    cmd(3, 0, 1, 0);
    cmd(5, 0, 1, 1); chk("t3_add1", last_data, 1);
    chk("t3_add_latency", last_lat, 4);
    cmd(5, 0, 1, 1); chk("t3_add2", last_data, 2);
    cmd(3, 0, 3, 4095);
    cmd(5, 0, 3, 1); chk("t3_wrap", last_data, 0);
    cmd(4, 0, 0, 0); chk("t3_size4", last_data, 4);
    // errors and boundaries
    cmd(3, 0, 9, 33);
    cmd(4, 0, 0, 0); chk("t4_size_max", last_data, 10);
    cmd(2, 0, 10, 0); chk("t4_bounds", last_err, 1);
    chk("t4_bounds_data", last_data, 0);
    cmd(1, 1, 0, 0); chk("t4_free_ok", last_err, 0);
    cmd(1, 1, 0, 0); chk("t4_double_free", last_err, 2);
    cmd(2, 5, 0, 0); chk("t4_unalloc_read", last_err, 2);
    cmd(4, 250, 0, 0); chk("t4_array_range", last_err, 2);
    cmd(6, 0, 0, 0); chk("t4_illegal_op", last_err, 3);
    cmd(7, 0, 12, 0); chk("t4_illegal_first", last_err, 3);
    cmd(2, 0, 9, 0); chk("t4_read_last", last_data, 33);
    cmd(4, 0, 0, 0); chk("t4_size_unchanged", last_data, 10);
    chk("t4_in_use", in_use, 1);
    // exhaustion: array 1 is on the free stack, then 2..199 are fresh
    for (int n = 0; n < 199; n++) begin
      cmd(0, 0, 0, 0);
      chk("t5_alloc", last_data, n + 1);
    end
    cmd(0, 0, 0, 0); chk("t5_full", last_err, 3);
    chk("t5_full_data", last_data, 0);
    chk("t5_allocs", allocs, 200);
    cmd(1, 2, 0, 0);
    cmd(0, 0, 0, 0); chk("t5_realloc", last_data, 2);
    // backpressure on a read response
    cmd(3, 2, 5, 1234);
    cmd(2, 2, 5, 0, 5); chk("t6_held_read", last_data, 1234);
    // reset during ADD read-modify-write
    cmd(5, 0, 1, 1, 0, 1);
    cmd(0, 0, 0, 0); chk("t6_alloc_after_reset", last_data, 0);
    chk("t6_allocs_after_reset", allocs, 1);
    // random traffic
    repeat (300) begin
      r = $urandom_range(0, 9);
      op = r < 2 ? 0 : r == 2 ? 1 : r == 3 ? 2 : r < 6 ? 3 : r == 6 ? 4 : r == 7 ? 5
         : r == 8 ? $urandom_range(6, 7) : $urandom_range(0, 7);
      a = $urandom_range(0, 7) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 15);
      cmd(op, a, $urandom_range(0, 11), $urandom_range(0, 4095), $urandom_range(0, 7) == 0 ? 2 : 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
